// File: rtl/demux_pkg.sv
// Shared constants and width helpers for the 1-to-N demux with per-channel FIFOs.
package demux_pkg;

    localparam int DEF_DATA_WIDTH = 2;
    localparam int DEF_N_OUT      = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_MODE_RR    = 0;

    // Selector width is max(1, clog2(n)).
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Count needs one extra bit so that a full FIFO is distinguishable from an empty one.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux_1_a_n_fifo_if.sv
// Handshake and data bundle between an upstream producer/consumer and the demux.
interface demux_1_a_n_fifo_if
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_OUT      = DEF_N_OUT
);
    localparam int SEL_W = sel_width(N_OUT);

    logic                        valid_in;
    logic [DATA_WIDTH-1:0]       data_in;
    logic [SEL_W-1:0]            selector;
    logic                        ready_in;
    logic [N_OUT-1:0]            valid_out;
    logic [N_OUT*DATA_WIDTH-1:0] data_out;
    logic [N_OUT-1:0]            pop;
    logic [N_OUT-1:0]            full;
    logic                        err_sel;
    logic [N_OUT-1:0]            err_pop;

    modport master (
        output valid_in, data_in, selector, pop,
        input  ready_in, valid_out, data_out, full, err_sel, err_pop
    );

    modport slave (
        input  valid_in, data_in, selector, pop,
        output ready_in, valid_out, data_out, full, err_sel, err_pop
    );

endinterface

// File: rtl/demux_fifo_channel.sv
// Single-channel FIFO: head word visible one cycle after the push edge, zero when empty.
// Pushes while full are ignored; pops while empty only set the sticky err_pop flag.
module demux_fifo_channel
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  full,
    output logic                  err_pop
);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int PTR_W = CNT_W - 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign rd_dat  = valid ? mem[rd_ptr] : '0;

    // Storage carries no reset; the count gates every read so stale words never leak out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_pop <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            err_pop <= err_pop | (pop & ~valid);
        end
    end

endmodule

// File: rtl/demux_1_a_n_fifo.sv
// Routes each accepted word to one of N_OUT FIFOs (by selector or round-robin); 1-cycle latency.
// ready_in drops when the target FIFO is full; out-of-range selectors are accepted and dropped.
module demux_1_a_n_fifo
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_OUT      = DEF_N_OUT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MODE_RR    = DEF_MODE_RR
) (
    input  logic               clk,
    input  logic               reset_L,
    demux_1_a_n_fifo_if.slave  bus
);
    localparam int SEL_W = sel_width(N_OUT);

    logic [SEL_W-1:0]            rr_ptr;
    logic [SEL_W-1:0]            target;
    logic                        sel_ok;
    logic                        tgt_full;
    logic                        ready;
    logic                        accept;
    logic                        err_sel;
    logic [N_OUT-1:0]            push_vec;
    logic [N_OUT-1:0]            valid_vec;
    logic [N_OUT-1:0]            full_vec;
    logic [N_OUT-1:0]            err_pop_vec;
    logic [N_OUT*DATA_WIDTH-1:0] data_flat;

    // ready_in is derived from registered full flags only, never from pop in the same cycle.
    always_comb begin
        target   = (MODE_RR != 0) ? rr_ptr : bus.selector;
        sel_ok   = (MODE_RR != 0) || (int'(bus.selector) < N_OUT);
        tgt_full = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (target == SEL_W'(k)) begin
                tgt_full = full_vec[k];
            end
        end
        ready  = reset_L & (~sel_ok | ~tgt_full);
        accept = bus.valid_in & ready;
        push_vec = '0;
        for (int k = 0; k < N_OUT; k++) begin
            push_vec[k] = accept & sel_ok & (target == SEL_W'(k));
        end
    end

    // rr_ptr moves only on accept, so a full target stalls the stream instead of skipping it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr  <= '0;
            err_sel <= 1'b0;
        end else begin
            if ((MODE_RR != 0) && accept) begin
                rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + SEL_W'(1);
            end
            err_sel <= err_sel | (bus.valid_in & ~sel_ok);
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        demux_fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_ch (
            .clk     (clk),
            .reset_L (reset_L),
            .push    (push_vec[k]),
            .wr_dat  (bus.data_in),
            .pop     (bus.pop[k]),
            .valid   (valid_vec[k]),
            .rd_dat  (data_flat[k*DATA_WIDTH +: DATA_WIDTH]),
            .full    (full_vec[k]),
            .err_pop (err_pop_vec[k])
        );
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_vec;
    assign bus.data_out  = data_flat;
    assign bus.full      = full_vec;
    assign bus.err_sel   = err_sel;
    assign bus.err_pop   = err_pop_vec;

endmodule

// File: tb/tb_demux_1_a_n_fifo.sv
// Directed bench: selector mode (N=4), round-robin mode (N=4), out-of-range selector (N=3).
module tb_demux_1_a_n_fifo;

    logic clk = 1'b0;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    demux_1_a_n_fifo_if #(.DATA_WIDTH(2), .N_OUT(4)) b0 ();
    demux_1_a_n_fifo_if #(.DATA_WIDTH(2), .N_OUT(4)) b1 ();
    demux_1_a_n_fifo_if #(.DATA_WIDTH(2), .N_OUT(3)) b2 ();

    demux_1_a_n_fifo #(.DATA_WIDTH(2), .N_OUT(4), .FIFO_DEPTH(4), .MODE_RR(0)) u0 (
        .clk(clk), .reset_L(reset_L), .bus(b0.slave));
    demux_1_a_n_fifo #(.DATA_WIDTH(2), .N_OUT(4), .FIFO_DEPTH(4), .MODE_RR(1)) u1 (
        .clk(clk), .reset_L(reset_L), .bus(b1.slave));
    demux_1_a_n_fifo #(.DATA_WIDTH(2), .N_OUT(3), .FIFO_DEPTH(4), .MODE_RR(0)) u2 (
        .clk(clk), .reset_L(reset_L), .bus(b2.slave));

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [1:0] d;
        logic [3:0] pop;
        logic       rdy;
        logic [3:0] vout;
        logic [7:0] dout;
        logic [3:0] full;
        logic [3:0] errp;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic [1:0] d,
                                input logic [3:0] pop, input logic rdy, input logic [3:0] vout,
                                input logic [7:0] dout, input logic [3:0] full,
                                input logic [3:0] errp);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.pop = pop; r.rdy = rdy;
        r.vout = vout; r.dout = dout; r.full = full; r.errp = errp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Expected values describe outputs just before the edge that applies the row's inputs.
        //             v     sel   d     pop      rdy   vout     dout   full     errp
        tbl[0]  = mk(1'b0, 2'd0, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
        tbl[1]  = mk(1'b1, 2'd2, 2'd3, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
        tbl[2]  = mk(1'b0, 2'd2, 2'd0, 4'b0000, 1'b1, 4'b0100, 8'h30, 4'b0000, 4'b0000);
        tbl[3]  = mk(1'b0, 2'd2, 2'd0, 4'b0100, 1'b1, 4'b0100, 8'h30, 4'b0000, 4'b0000);
        tbl[4]  = mk(1'b1, 2'd1, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
        tbl[5]  = mk(1'b1, 2'd1, 2'd1, 4'b0000, 1'b1, 4'b0010, 8'h00, 4'b0000, 4'b0000);
        tbl[6]  = mk(1'b1, 2'd1, 2'd2, 4'b0000, 1'b1, 4'b0010, 8'h00, 4'b0000, 4'b0000);
        tbl[7]  = mk(1'b1, 2'd1, 2'd3, 4'b0000, 1'b1, 4'b0010, 8'h00, 4'b0000, 4'b0000);
        tbl[8]  = mk(1'b1, 2'd1, 2'd2, 4'b0000, 1'b0, 4'b0010, 8'h00, 4'b0010, 4'b0000);
        tbl[9]  = mk(1'b1, 2'd1, 2'd2, 4'b0010, 1'b0, 4'b0010, 8'h00, 4'b0010, 4'b0000);
        tbl[10] = mk(1'b0, 2'd1, 2'd0, 4'b0010, 1'b1, 4'b0010, 8'h04, 4'b0000, 4'b0000);
        tbl[11] = mk(1'b0, 2'd1, 2'd0, 4'b0010, 1'b1, 4'b0010, 8'h08, 4'b0000, 4'b0000);
        tbl[12] = mk(1'b0, 2'd1, 2'd0, 4'b0010, 1'b1, 4'b0010, 8'h0C, 4'b0000, 4'b0000);
        tbl[13] = mk(1'b0, 2'd1, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
        tbl[14] = mk(1'b1, 2'd0, 2'd1, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
        tbl[15] = mk(1'b1, 2'd0, 2'd2, 4'b0000, 1'b1, 4'b0001, 8'h01, 4'b0000, 4'b0000);
        tbl[16] = mk(1'b1, 2'd0, 2'd3, 4'b0001, 1'b1, 4'b0001, 8'h01, 4'b0000, 4'b0000);
        tbl[17] = mk(1'b0, 2'd0, 2'd0, 4'b1001, 1'b1, 4'b0001, 8'h02, 4'b0000, 4'b0000);
        tbl[18] = mk(1'b0, 2'd0, 2'd0, 4'b0001, 1'b1, 4'b0001, 8'h03, 4'b0000, 4'b1000);
        tbl[19] = mk(1'b0, 2'd0, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b1000);
        tbl[20] = mk(1'b1, 2'd3, 2'd2, 4'b1000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b1000);
        tbl[21] = mk(1'b0, 2'd3, 2'd0, 4'b0000, 1'b1, 4'b1000, 8'h80, 4'b0000, 4'b1000);
        tbl[22] = mk(1'b0, 2'd3, 2'd0, 4'b1000, 1'b1, 4'b1000, 8'h80, 4'b0000, 4'b1000);
        tbl[23] = mk(1'b0, 2'd0, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b1000);

        b0.valid_in = 1'b1; b0.data_in = '0; b0.selector = '0; b0.pop = '0;
        b1.valid_in = 1'b1; b1.data_in = '0; b1.selector = '0; b1.pop = '0;
        b2.valid_in = 1'b0; b2.data_in = '0; b2.selector = '0; b2.pop = '0;
        reset_L = 1'b0;

        // Reset state, with valid_in held high to show ready_in stays low.
        #2;
        chk("rst_rdy0", b0.ready_in, 1'b0);
        chk("rst_rdy1", b1.ready_in, 1'b0);
        chk("rst_vout", b0.valid_out, 4'b0000);
        chk("rst_dout", b0.data_out, 8'h00);
        chk("rst_full", b0.full, 4'b0000);
        chk("rst_errs", b2.err_sel, 1'b0);
        b0.valid_in = 1'b0;
        b1.valid_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            b0.valid_in = tbl[i].v;
            b0.selector = tbl[i].sel;
            b0.data_in  = tbl[i].d;
            b0.pop      = tbl[i].pop;
            #1;
            chk($sformatf("v%0d_rdy", i),  b0.ready_in,  tbl[i].rdy);
            chk($sformatf("v%0d_vout", i), b0.valid_out, tbl[i].vout);
            chk($sformatf("v%0d_dout", i), b0.data_out,  tbl[i].dout);
            chk($sformatf("v%0d_full", i), b0.full,      tbl[i].full);
            chk($sformatf("v%0d_errp", i), b0.err_pop,   tbl[i].errp);
        end
        @(negedge clk);
        b0.valid_in = 1'b0; b0.pop = '0;
        chk("u0_err_sel", b0.err_sel, 1'b0);

        // Round-robin: words 0..7 land two per channel; data {i[2],i[0]} tells first from second.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b1.valid_in = 1'b1;
            b1.data_in  = {i[2], i[0]};
            #1;
            chk($sformatf("rr_push%0d_rdy", i), b1.ready_in, 1'b1);
        end
        @(negedge clk);
        b1.valid_in = 1'b0;
        #1;
        chk("rr_vout8", b1.valid_out, 4'b1111);
        chk("rr_head1", b1.data_out, 8'h44);
        @(negedge clk);
        b1.pop = 4'b1111;
        @(negedge clk);
        #1;
        chk("rr_head2", b1.data_out, 8'hEE);
        @(negedge clk);
        b1.pop = 4'b0000;
        #1;
        chk("rr_drained", b1.valid_out, 4'b0000);

        // Fill channel 2 while draining the others: 18 accepts leave rr_ptr on full channel 2.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            b1.valid_in = 1'b1;
            b1.data_in  = i[1:0];
            b1.pop      = b1.valid_out & 4'b1011;
            #1;
            chk($sformatf("rr_fill%0d_rdy", i), b1.ready_in, 1'b1);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            b1.valid_in = 1'b1;
            b1.pop      = 4'b0000;
            #1;
            chk($sformatf("rr_hold%0d_rdy", j), b1.ready_in, 1'b0);
            chk($sformatf("rr_hold%0d_full2", j), b1.full[2], 1'b1);
        end
        @(negedge clk);
        b1.pop = 4'b0100;
        #1;
        chk("rr_pop2_rdy", b1.ready_in, 1'b0);
        @(negedge clk);
        b1.pop = 4'b0000;
        #1;
        chk("rr_after_pop_rdy", b1.ready_in, 1'b1);
        @(negedge clk);
        b1.valid_in = 1'b0;
        #1;
        chk("rr_refill_full", b1.full, 4'b0100);
        chk("rr_refill_vout", b1.valid_out, 4'b0110);

        // Out-of-range selector on a 3-channel block.
        @(negedge clk);
        b2.valid_in = 1'b1; b2.selector = 2'd0; b2.data_in = 2'd1;
        #1;
        chk("oor_push_rdy", b2.ready_in, 1'b1);
        @(negedge clk);
        b2.selector = 2'd3; b2.data_in = 2'd2;
        #1;
        chk("oor_rdy", b2.ready_in, 1'b1);
        chk("oor_err_pre", b2.err_sel, 1'b0);
        @(negedge clk);
        b2.valid_in = 1'b0; b2.selector = 2'd0;
        #1;
        chk("oor_err", b2.err_sel, 1'b1);
        chk("oor_vout", b2.valid_out, 3'b001);
        chk("oor_dout", b2.data_out, 6'b000001);
        @(negedge clk);
        #1;
        chk("oor_sticky", b2.err_sel, 1'b1);

        // Reset mid-stream with three words queued.
        @(negedge clk);
        b0.valid_in = 1'b1; b0.selector = 2'd0; b0.data_in = 2'd1;
        @(negedge clk);
        b0.selector = 2'd1; b0.data_in = 2'd2;
        @(negedge clk);
        b0.selector = 2'd2; b0.data_in = 2'd3;
        @(negedge clk);
        b0.valid_in = 1'b0;
        #1;
        chk("mid_vout", b0.valid_out, 4'b0111);
        chk("mid_dout", b0.data_out, 8'h39);
        #2;
        reset_L = 1'b0;
        #1;
        chk("mid_rst_vout", b0.valid_out, 4'b0000);
        chk("mid_rst_dout", b0.data_out, 8'h00);
        chk("mid_rst_rdy", b0.ready_in, 1'b0);
        chk("mid_rst_errp", b0.err_pop, 4'b0000);
        chk("mid_rst_errs", b2.err_sel, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        b0.valid_in = 1'b1; b0.selector = 2'd0; b0.data_in = 2'd3;
        #1;
        chk("rel_vout", b0.valid_out, 4'b0000);
        chk("rel_rdy", b0.ready_in, 1'b1);
        @(negedge clk);
        b0.valid_in = 1'b0;
        #1;
        chk("rel_first_vout", b0.valid_out, 4'b0001);
        chk("rel_first_dout", b0.data_out, 8'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1_a_n_fifo.md
DEMUX_1_A_N_FIFO -- requirements
Module: demux_1_a_n_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 2: width of each data word.
REQ-002 Parameter N_OUT, default 2: number of output channels, legal range 2..8.
REQ-003 Parameter FIFO_DEPTH, default 4: words per channel FIFO, power of 2, minimum 2.
REQ-004 Parameter MODE_RR, default 0: 0 = channel chosen by selector, 1 = round-robin with selector ignored.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset_L, input, 1: reset, asynchronous, active-low.
REQ-007 Port valid_in, input, 1: input word present.
REQ-008 Port data_in, input, DATA_WIDTH: input word.
REQ-009 Port selector, input, SEL_W = max(1, clog2(N_OUT)): target channel when MODE_RR = 0.
REQ-010 Port ready_in, output, 1: the block accepts data_in this cycle.
REQ-011 Port valid_out, output, N_OUT: bit k set means channel k FIFO is non-empty.
REQ-012 Port data_out, output, N_OUT*DATA_WIDTH: slice k is the head word of channel k.
REQ-013 Port pop, input, N_OUT: bit k consumes the head word of channel k.
REQ-014 Port full, output, N_OUT: bit k set means channel k holds FIFO_DEPTH words.
REQ-015 Port err_sel, output, 1: sticky; set when a selector value is out of range.
REQ-016 Port err_pop, output, N_OUT: sticky per channel; set on pop while empty.

Function
REQ-017 Target channel: equals selector when MODE_RR = 0, or the rr_ptr register when MODE_RR = 1.
REQ-018 ready_in: equals ~full[target], combinational from registered state only.
REQ-019 Accept condition: valid_in & ready_in; the accepted word is written to the tail of the target FIFO on that clock edge.
REQ-020 Latency: an accepted word appears on data_out/valid_out of an empty channel one cycle after acceptance, with no combinational data path from data_in to data_out.
REQ-021 Output slices: data_out slice k is 0 when channel k is empty, never X.
REQ-022 Pop: pop[k] & valid_out[k] removes the head on the edge, and the next word (or 0) is presented the following cycle.
REQ-023 Pop on empty: pop[k] while valid_out[k] = 0 causes no state change except setting err_pop[k].
REQ-024 Push and pop on the same non-empty channel in the same cycle: both take effect and the count is unchanged.
REQ-025 Full channel: a push is blocked (ready_in = 0) even if the same channel pops that cycle, because full is registered.
REQ-026 Empty channel with push and pop in the same cycle: the push takes effect and the pop is ignored and flagged per REQ-023.
REQ-027 Round-robin pointer: rr_ptr advances modulo N_OUT only on accept; it holds while its target is full, so words are never skipped or reordered.
REQ-028 Out-of-range selector: selector >= N_OUT in MODE_RR = 0 with valid_in gives ready_in = 1, the word is dropped, and err_sel is set.
REQ-029 Ordering: each channel is strict FIFO order, and channels are independent of one another.
REQ-030 Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH; count is held in clog2(FIFO_DEPTH)+1 bits.
REQ-031 Error flags: err_sel and err_pop clear only on reset.

Reset
REQ-032 While reset_L = 0: all FIFOs are empty, all pointers and counts are 0, rr_ptr = 0, and err flags = 0.
REQ-033 Outputs during reset: valid_out = 0, data_out = 0, full = 0, and ready_in = 0, independent of clk.
REQ-034 Reset mid-operation: reset asserted mid-operation discards all stored words immediately.
REQ-035 Reset release: the first accept is possible on the first rising edge after reset_L rises.

Structure
REQ-036 Shared package demux_pkg: holds the default parameter constants and the SEL_W/count-width calculation function.
REQ-037 Sub-module demux_fifo_channel: one FIFO holding data, pointers, count, full/empty and err_pop, instantiated N_OUT times in a generate loop.
REQ-038 Top level: contains only target selection, rr_ptr, ready_in and err_sel.

Verification (DATA_WIDTH=2, N_OUT=4, FIFO_DEPTH=4)
REQ-039 Reset and directed push: assert reset, release, push 2'b11 with selector=2 -> next cycle valid_out=4'b0100, slice 2 = 2'b11, other slices 0.
REQ-040 Fill and blocked push: fill channel 1 with 0,1,2,3 -> full[1]=1 and ready_in=0 for selector=1; a fifth push is not accepted; pops return 0,1,2,3 in order.
REQ-041 Simultaneous push/pop: push/pop on channel 0 holding 2 words -> count stays 2 and order is preserved; pop on empty channel 3 -> err_pop[3]=1 with no data change.
REQ-042 Round-robin mode: MODE_RR=1, push 8 words -> two words per channel in order 0,1,2,3,0,1,2,3; with channel 2 full, rr_ptr holds at 2 and ready_in=0 until pop[2].
REQ-043 Out-of-range selector: N_OUT=3, selector=3 with valid_in -> ready_in=1, word dropped, err_sel=1, all FIFOs unchanged.
REQ-044 Reset mid-stream: reset_L low mid-stream with 3 words queued -> valid_out=0 and data_out=0 asynchronously; after release, all channels are empty.
